// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter.
// Master 0 is the data-memory port and master 1 is the instruction-fetch port.
// Each grant covers one whole bus cycle, from the rise of cyc to its fall.
// Master 1 uses the same port set and widths as master 0.
//
// ARB_MODE selects the arbitration policy:
//   0 = round-robin
//   1 = fixed priority, with master 0 highest
//
// Optional build macro WB_ARB_TIMEOUT_EN adds an ack watchdog.
// A granted cycle that waits TIMEOUT_CYCLES strobe cycles with no ack is
// aborted. The watchdog then pulses the owning master's err output once.
// Without the macro both err outputs are tied low.
module wb_arbiter_2m #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [ADDR_WIDTH-1:0]     m0_adr_i,
    input  logic [DATA_WIDTH-1:0]     m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,
    output logic [DATA_WIDTH-1:0]     m0_dat_o,
    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [ADDR_WIDTH-1:0]     m1_adr_i,
    input  logic [DATA_WIDTH-1:0]     m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,
    output logic [DATA_WIDTH-1:0]     m1_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADDR_WIDTH-1:0]     s_adr_o,
    output logic [DATA_WIDTH-1:0]     s_dat_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    input  logic                      s_ack_i,
    input  logic [DATA_WIDTH-1:0]     s_dat_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT0  = 2'd1;
    localparam logic [1:0] ST_GNT1  = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    // last_gnt_r also identifies the owner of the current grant or abort.
    logic       last_gnt_r;
    logic       last_gnt_nxt_s;
    logic       timeout_hit_s;
    logic       abort_cyc_s;

    // Read data fans out to both masters; only the granted one sees ack.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // In ABORT, this is the cyc line of the master whose cycle was cut off.
    assign abort_cyc_s = last_gnt_r ? m1_cyc_i : m0_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_r;
    logic        err0_r;
    logic        err1_r;
    logic        granted_s;

    assign granted_s     = (state_r == ST_GNT0) || (state_r == ST_GNT1);
    assign timeout_hit_s = (to_cnt_r == TO_LAST) && !s_ack_i;
    assign m0_err_o      = err0_r;
    assign m1_err_o      = err1_r;

    // Watchdog: count unacked strobe cycles of the current grant; idle states and acks clear it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_r <= 16'd0;
        end else if (!granted_s || s_ack_i) begin
            to_cnt_r <= 16'd0;
        end else if (s_stb_o) begin
            to_cnt_r <= to_cnt_r + 16'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Error pulse: high only in the first ABORT cycle, routed to the master that lost its cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err0_r <= 1'b0;
            err1_r <= 1'b0;
        end else begin
            err0_r <= (state_r == ST_GNT0) && (state_nxt_s == ST_ABORT);
            err1_r <= (state_r == ST_GNT1) && (state_nxt_s == ST_ABORT);
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign m0_err_o      = 1'b0;
    assign m1_err_o      = 1'b0;
`endif

    // Next-state and grant-history logic for the arbitration FSM.
    always_comb begin
        state_nxt_s    = state_r;
        last_gnt_nxt_s = last_gnt_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if ((ARB_MODE == 1) || last_gnt_r) begin
                        state_nxt_s    = ST_GNT0;
                        last_gnt_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s    = ST_GNT1;
                        last_gnt_nxt_s = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_nxt_s    = ST_GNT0;
                    last_gnt_nxt_s = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt_s    = ST_GNT1;
                    last_gnt_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_ABORT;
                end else begin
                    state_nxt_s = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_ABORT;
                end else begin
                    state_nxt_s = ST_GNT1;
                end
            end
            ST_ABORT: begin
                // Hold off the bus until the aborted master gives up its cycle.
                if (!abort_cyc_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ABORT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset parks on master 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            last_gnt_r <= last_gnt_nxt_s;
        end
    end

    // Slave-side mux and ack steering.
    // This stays combinational so the granted master reaches the slave with no added latency.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = {ADDR_WIDTH{1'b0}};
        s_dat_o  = {DATA_WIDTH{1'b0}};
        s_sel_o  = {SEL_WIDTH{1'b0}};
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state_r)
            ST_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
            end
            ST_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
            end
            default: begin
                // IDLE and ABORT: bus quiet, stray acks dropped.
                s_cyc_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m.
// Two instances are exercised side by side:
//   u_rr runs round-robin (index 0)
//   u_fp runs fixed priority (index 1)
// One process drives the masters and a simple slave model cycle by cycle.
// A monitor records each grant start: the owning master and the number of
// cycles s_cyc was low before it. Test tasks push the expected grants into a
// queue and compare them against the recorded ones.
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam logic [AW-1:0] ADR0 = 32'h8000_0010;
    localparam logic [AW-1:0] ADR1 = 32'h0000_1000;

    typedef struct {
        int master;
        int gap;
    } grant_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]    m_cyc  [2];
    logic [1:0]    m_stb  [2];
    logic [1:0]    m_we   [2];
    logic [AW-1:0] m_adr  [2][2];
    logic [DW-1:0] m_wdat [2][2];
    logic [SW-1:0] m_sel  [2][2];
    logic [1:0]    m_ack  [2];
    logic [1:0]    m_err  [2];
    logic [DW-1:0] m_rdat [2][2];
    logic          s_cyc  [2];
    logic          s_stb  [2];
    logic          s_we   [2];
    logic [AW-1:0] s_adr  [2];
    logic [DW-1:0] s_wdat [2];
    logic [SW-1:0] s_sel  [2];
    logic          s_ack  [2];
    logic [DW-1:0] s_rdat [2];

    int       m_auto   [2][2];   // 0 manual, 1 continuous requester, 2 single transfer
    int       slv_auto [2];
    int       slv_lat  [2];
    int       slv_wcnt [2];
    logic [1:0] ack_seen [2];
    int       ack_cnt  [2][2];
    int       err_cnt  [2][2];
    logic     prev_cyc [2];
    int       idle_run [2];
    grant_t   obs0_q[$];
    grant_t   obs1_q[$];
    grant_t   exp_q[$];
    grant_t   e;
    grant_t   o;
    int       checks   = 0;
    int       failures = 0;
    int       gcnt;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .TIMEOUT_CYCLES(4)) u_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m_cyc[0][0]), .m0_stb_i(m_stb[0][0]), .m0_we_i(m_we[0][0]),
        .m0_adr_i(m_adr[0][0]), .m0_dat_i(m_wdat[0][0]), .m0_sel_i(m_sel[0][0]),
        .m0_ack_o(m_ack[0][0]), .m0_err_o(m_err[0][0]), .m0_dat_o(m_rdat[0][0]),
        .m1_cyc_i(m_cyc[0][1]), .m1_stb_i(m_stb[0][1]), .m1_we_i(m_we[0][1]),
        .m1_adr_i(m_adr[0][1]), .m1_dat_i(m_wdat[0][1]), .m1_sel_i(m_sel[0][1]),
        .m1_ack_o(m_ack[0][1]), .m1_err_o(m_err[0][1]), .m1_dat_o(m_rdat[0][1]),
        .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_we_o(s_we[0]), .s_adr_o(s_adr[0]),
        .s_dat_o(s_wdat[0]), .s_sel_o(s_sel[0]), .s_ack_i(s_ack[0]), .s_dat_i(s_rdat[0])
    );

    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .TIMEOUT_CYCLES(4)) u_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m_cyc[1][0]), .m0_stb_i(m_stb[1][0]), .m0_we_i(m_we[1][0]),
        .m0_adr_i(m_adr[1][0]), .m0_dat_i(m_wdat[1][0]), .m0_sel_i(m_sel[1][0]),
        .m0_ack_o(m_ack[1][0]), .m0_err_o(m_err[1][0]), .m0_dat_o(m_rdat[1][0]),
        .m1_cyc_i(m_cyc[1][1]), .m1_stb_i(m_stb[1][1]), .m1_we_i(m_we[1][1]),
        .m1_adr_i(m_adr[1][1]), .m1_dat_i(m_wdat[1][1]), .m1_sel_i(m_sel[1][1]),
        .m1_ack_o(m_ack[1][1]), .m1_err_o(m_err[1][1]), .m1_dat_o(m_rdat[1][1]),
        .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_we_o(s_we[1]), .s_adr_o(s_adr[1]),
        .s_dat_o(s_wdat[1]), .s_sel_o(s_sel[1]), .s_ack_i(s_ack[1]), .s_dat_i(s_rdat[1])
    );

    // One clock cycle of environment.
    // Models update 1 time unit after the rising edge.
    // The monitor samples on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            // Slave: ack for one cycle once strobe has been seen slv_lat times.
            if (slv_auto[d] != 0) begin
                if (s_ack[d]) begin
                    s_ack[d] = 1'b0;
                end else if (s_cyc[d] && s_stb[d]) begin
                    slv_wcnt[d]++;
                    if (slv_wcnt[d] >= slv_lat[d]) begin
                        s_ack[d]    = 1'b1;
                        slv_wcnt[d] = 0;
                    end
                end else begin
                    slv_wcnt[d] = 0;
                end
            end
            // Masters release cyc the cycle after their ack and re-request one cycle later.
            for (int m = 0; m < 2; m++) begin
                if (m_auto[d][m] != 0) begin
                    if (m_cyc[d][m] && ack_seen[d][m]) begin
                        m_cyc[d][m] = 1'b0;
                        m_stb[d][m] = 1'b0;
                        if (m_auto[d][m] == 2) m_auto[d][m] = 0;
                    end else if (!m_cyc[d][m]) begin
                        m_cyc[d][m] = 1'b1;
                        m_stb[d][m] = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                ack_seen[d][m] = m_ack[d][m];
                if (m_ack[d][m]) ack_cnt[d][m]++;
                if (m_err[d][m]) err_cnt[d][m]++;
            end
            if (s_cyc[d]) begin
                if (!prev_cyc[d]) begin
                    if (d == 0) obs0_q.push_back('{(s_adr[d] == ADR1) ? 1 : 0, idle_run[d]});
                    else        obs1_q.push_back('{(s_adr[d] == ADR1) ? 1 : 0, idle_run[d]});
                end
                idle_run[d] = 0;
            end else begin
                idle_run[d]++;
            end
            prev_cyc[d] = s_cyc[d];
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                m_cyc[d][m] = 1'b0; m_stb[d][m] = 1'b0; m_we[d][m] = 1'b0;
                m_adr[d][m] = (m == 0) ? ADR0 : ADR1;
                m_wdat[d][m] = '0; m_sel[d][m] = 4'hF;
                m_auto[d][m] = 0; ack_seen[d][m] = 1'b0;
                ack_cnt[d][m] = 0; err_cnt[d][m] = 0;
            end
            s_ack[d] = 1'b0; s_rdat[d] = '0;
            slv_auto[d] = 0; slv_lat[d] = 1; slv_wcnt[d] = 0;
            prev_cyc[d] = 1'b0; idle_run[d] = 0;
        end
        obs0_q.delete(); obs1_q.delete(); exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_cyc[d][0] = 1'b1; m_stb[d][0] = 1'b1; m_we[d][0] = 1'b1;
            s_ack[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({s_cyc[d], s_stb[d], s_we[d], s_adr[d], s_wdat[d], s_sel[d], m_ack[d], m_err[d]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: got %h expected 0", d,
                         {s_cyc[d], s_stb[d], s_we[d], s_adr[d], s_wdat[d], s_sel[d], m_ack[d], m_err[d]});
            end
        end
        for (int d = 0; d < 2; d++) s_ack[d] = 1'b0;
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({s_cyc[d], m_ack[d], m_err[d]} !== 5'b0) begin
                failures++;
                $display("FAIL release_idle[%0d]: got %b expected 00000", d, {s_cyc[d], m_ack[d], m_err[d]});
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (s_cyc[d] !== 1'b1) begin
                failures++;
                $display("FAIL first_grant[%0d]: s_cyc got %b expected 1", d, s_cyc[d]);
            end
        end
        // Asynchronous reset in mid-cycle must drop the slave cycle without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_cyc[0], s_cyc[1]} !== 2'b00) begin
            failures++;
            $display("FAIL async_reset_drop: s_cyc got %b expected 00", {s_cyc[0], s_cyc[1]});
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        slv_auto[0] = 1; slv_lat[0] = 3;
        m_adr[0][0] = ADR0; m_wdat[0][0] = 32'hDEAD_BEEF; m_sel[0][0] = 4'hF; m_we[0][0] = 1'b1;
        m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1; m_auto[0][0] = 2;
        exp_q.push_back('{0, -1});
        #1;
        checks++;
        if (s_cyc[0] !== 1'b0) begin
            failures++;
            $display("FAIL wr_before_edge: s_cyc got %b expected 0", s_cyc[0]);
        end
        tick();
        checks++;
        if ({s_cyc[0], s_stb[0], s_we[0]} !== 3'b111) begin
            failures++;
            $display("FAIL wr_ctrl: cyc/stb/we got %b expected 111", {s_cyc[0], s_stb[0], s_we[0]});
        end
        checks++;
        if (s_adr[0] !== 32'h8000_0010 || s_wdat[0] !== 32'hDEAD_BEEF || s_sel[0] !== 4'hF) begin
            failures++;
            $display("FAIL wr_bus: adr %h dat %h sel %h expected 80000010 deadbeef f", s_adr[0], s_wdat[0], s_sel[0]);
        end
        for (int n = 0; n < 20 && m_auto[0][0] != 0; n++) tick();
        repeat (2) tick();
        checks++;
        if (ack_cnt[0][0] !== 1 || ack_cnt[0][1] !== 0 || err_cnt[0][0] !== 0) begin
            failures++;
            $display("FAIL wr_acks: m0 %0d m1 %0d err %0d expected 1 0 0", ack_cnt[0][0], ack_cnt[0][1], err_cnt[0][0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs0_q.size() == 0) begin
                failures++;
                $display("FAIL wr_grant: got none expected master %0d", e.master);
            end else begin
                o = obs0_q.pop_front();
                if (o.master !== e.master) begin
                    failures++;
                    $display("FAIL wr_grant: got master %0d expected %0d", o.master, e.master);
                end
            end
        end
    endtask

    // Both masters request all the time; each cycle is acked after one strobe.
    // Between grants s_cyc stays low for 2 cycles:
    //   - the cycle after ack, while the master drops cyc
    //   - the arbiter's IDLE cycle
    task automatic test_round_robin();
        apply_reset();
        slv_auto[0] = 1; slv_lat[0] = 1;
        m_auto[0][0] = 1; m_auto[0][1] = 1;
        exp_q.push_back('{0, -1});
        exp_q.push_back('{1, 2});
        exp_q.push_back('{0, 2});
        exp_q.push_back('{1, 2});
        for (int n = 0; n < 60 && obs0_q.size() < 4; n++) tick();
        m_auto[0][0] = 0; m_auto[0][1] = 0;
        m_cyc[0] = 2'b00; m_stb[0] = 2'b00;
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs0_q.size() == 0) begin
                failures++;
                $display("FAIL rr_grant: got none expected master %0d", e.master);
            end else begin
                o = obs0_q.pop_front();
                if (o.master !== e.master || (e.gap >= 0 && o.gap !== e.gap)) begin
                    failures++;
                    $display("FAIL rr_grant: got master %0d gap %0d expected master %0d gap %0d",
                             o.master, o.gap, e.master, e.gap);
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        slv_auto[1] = 1; slv_lat[1] = 1;
        m_auto[1][0] = 1; m_auto[1][1] = 1;
        exp_q.push_back('{0, -1});
        exp_q.push_back('{0, 2});
        exp_q.push_back('{0, 2});
        exp_q.push_back('{1, 2});
        for (int n = 0; n < 60 && obs1_q.size() < 3; n++) tick();
        // Master 0 finishes its current cycle and then stays off the bus.
        m_auto[1][0] = 2;
        for (int n = 0; n < 30 && obs1_q.size() < 4; n++) tick();
        m_auto[1][1] = 2;
        repeat (6) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs1_q.size() == 0) begin
                failures++;
                $display("FAIL fp_grant: got none expected master %0d", e.master);
            end else begin
                o = obs1_q.pop_front();
                if (o.master !== e.master || (e.gap >= 0 && o.gap !== e.gap)) begin
                    failures++;
                    $display("FAIL fp_grant: got master %0d gap %0d expected master %0d gap %0d",
                             o.master, o.gap, e.master, e.gap);
                end
            end
        end
    endtask

    task automatic test_read_ack_drop();
        apply_reset();
        m_adr[0][1] = ADR1; m_we[0][1] = 1'b0;
        m_cyc[0][1] = 1'b1; m_stb[0][1] = 1'b1;
        exp_q.push_back('{1, -1});
        exp_q.push_back('{0, 1});
        tick();
        checks++;
        if (s_cyc[0] !== 1'b1 || s_we[0] !== 1'b0 || s_adr[0] !== 32'h0000_1000) begin
            failures++;
            $display("FAIL rd_grant: cyc %b we %b adr %h expected 1 0 00001000", s_cyc[0], s_we[0], s_adr[0]);
        end
        m_adr[0][0] = ADR0; m_we[0][0] = 1'b1; m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1;
        tick();
        checks++;
        if (s_adr[0] !== 32'h0000_1000) begin
            failures++;
            $display("FAIL no_preempt: adr %h expected 00001000", s_adr[0]);
        end
        s_rdat[0] = 32'h1234_5678; s_ack[0] = 1'b1;
        m_cyc[0][1] = 1'b0; m_stb[0][1] = 1'b0;
        #1;
        checks++;
        if (m_ack[0] !== 2'b10 || m_rdat[0][1] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rd_ack_drop: acks(m1,m0) %b dat %h expected 10 12345678", m_ack[0], m_rdat[0][1]);
        end
        checks++;
        if (m_rdat[0][0] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rd_fanout: m0_dat %h expected 12345678", m_rdat[0][0]);
        end
        tick();
        // Arbiter is now IDLE with ack still asserted: nobody may see it.
        checks++;
        if (s_cyc[0] !== 1'b0 || m_ack[0] !== 2'b00) begin
            failures++;
            $display("FAIL idle_ack_drop: cyc %b acks %b expected 0 00", s_cyc[0], m_ack[0]);
        end
        s_ack[0] = 1'b0;
        tick();
        checks++;
        if (s_cyc[0] !== 1'b1 || s_adr[0] !== 32'h8000_0010) begin
            failures++;
            $display("FAIL pending_grant: cyc %b adr %h expected 1 80000010", s_cyc[0], s_adr[0]);
        end
        m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
        repeat (2) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs0_q.size() == 0) begin
                failures++;
                $display("FAIL rd_seq: got none expected master %0d", e.master);
            end else begin
                o = obs0_q.pop_front();
                if (o.master !== e.master || (e.gap >= 0 && o.gap !== e.gap)) begin
                    failures++;
                    $display("FAIL rd_seq: got master %0d gap %0d expected master %0d gap %0d",
                             o.master, o.gap, e.master, e.gap);
                end
            end
        end
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1;
        gcnt = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (s_cyc[0]) gcnt++;
            else if (gcnt > 0) break;
        end
        checks++;
        if (gcnt !== 4) begin
            failures++;
            $display("FAIL to_grant_cycles: got %0d expected 4", gcnt);
        end
        checks++;
        if (m_err[0] !== 2'b01 || s_cyc[0] !== 1'b0) begin
            failures++;
            $display("FAIL to_err_pulse: errs(m1,m0) %b cyc %b expected 01 0", m_err[0], s_cyc[0]);
        end
        s_ack[0] = 1'b1;
        #1;
        checks++;
        if (m_ack[0] !== 2'b00) begin
            failures++;
            $display("FAIL to_abort_ack: acks %b expected 00", m_ack[0]);
        end
        repeat (2) tick();
        checks++;
        if (m_err[0] !== 2'b00 || s_cyc[0] !== 1'b0 || err_cnt[0][0] !== 1) begin
            failures++;
            $display("FAIL to_abort_hold: errs %b cyc %b err_cycles %0d expected 00 0 1", m_err[0], s_cyc[0], err_cnt[0][0]);
        end
        s_ack[0] = 1'b0;
        m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
        tick();
        m_cyc[0][1] = 1'b1; m_stb[0][1] = 1'b1;
        tick();
        checks++;
        if (s_cyc[0] !== 1'b1 || s_adr[0] !== 32'h0000_1000) begin
            failures++;
            $display("FAIL to_recover: cyc %b adr %h expected 1 00001000", s_cyc[0], s_adr[0]);
        end
        m_cyc[0][1] = 1'b0; m_stb[0][1] = 1'b0;
        repeat (2) tick();
    endtask
`else
    task automatic test_no_timeout();
        apply_reset();
        m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1;
        gcnt = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (s_cyc[0]) gcnt++;
        end
        checks++;
        if (gcnt !== 12 || err_cnt[0][0] !== 0 || err_cnt[0][1] !== 0) begin
            failures++;
            $display("FAIL no_timeout: grant cycles %0d errs %0d/%0d expected 12 0/0", gcnt, err_cnt[0][0], err_cnt[0][1]);
        end
        m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
        repeat (2) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_fixed_priority();
        test_read_ack_drop();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter sharing the single SRAM/peripheral bus between the data-memory port (master 0) and the instruction-fetch port (master 1).
- Sits between both CPU-side Wishbone masters and the system bus slave.
- Grants whole bus cycles: a grant covers cyc rise to cyc fall.
- Arbitration is fixed-priority or round-robin, selected by parameter.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; sel width is DATA_WIDTH/8.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with master 0 highest.
- TIMEOUT_CYCLES, 255, ack timeout limit; used only with WB_ARB_TIMEOUT_EN; range 2..65535.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (data port) cycle, strobe, write enable.
- m0_adr_i  in  ADDR_WIDTH  master 0 address.
- m0_dat_i  in  DATA_WIDTH  master 0 write data.
- m0_sel_i  in  DATA_WIDTH/8  master 0 byte selects.
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge, timeout error.
- m0_dat_o  out  DATA_WIDTH  master 0 read data.
- m1_*  same set and widths as m0_*  master 1 (instruction fetch).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_sel_o  out  DATA_WIDTH/8  slave byte selects.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  DATA_WIDTH  slave read data.

Behaviour:
- States: IDLE, GNT0, GNT1, ABORT. ABORT is reachable only with WB_ARB_TIMEOUT_EN.
- Reset (rst_ni low, asynchronous):
  - state = IDLE; last_gnt = 1, so master 0 wins the first round-robin tie.
  - Timeout counter = 0.
  - All s_* outputs 0; m*_ack_o = 0; m*_err_o = 0.
  - Reset mid-transaction abandons the cycle immediately; the slave sees cyc drop asynchronously.
- IDLE:
  - s_cyc_o, s_stb_o, s_we_o = 0; s_adr_o, s_dat_o, s_sel_o = 0.
  - Requests are m0_cyc_i and m1_cyc_i.
  - Only one requesting: go to GNTx next edge.
  - Both requesting, ARB_MODE=1: go to GNT0.
  - Both requesting, ARB_MODE=0: grant the master that is not last_gnt.
  - last_gnt updates on the same edge as the grant.
- GNTx:
  - s_cyc/stb/we/adr/dat/sel are driven combinationally from master x.
  - mx_ack_o = s_ack_i; the other master's ack_o = 0.
  - s_dat_i fans out to both m0_dat_o and m1_dat_o unconditionally.
  - Exit to IDLE on the first edge where mx_cyc_i = 0.
  - The other master's request is ignored while the grant is held; no pre-emption.
- Latency:
  - Request sampled at edge N gives s_cyc_o high after edge N.
  - Minimum one IDLE cycle between consecutive grants, including back-to-back from the same master.
- Simultaneous events:
  - mx_cyc_i falling in the same cycle as s_ack_i: ack still reaches mx; state returns to IDLE.
  - A new request from the other master in that cycle is granted from IDLE on the following edge.
- Ack outside a grant: s_ack_i in IDLE is dropped; no master sees it.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to GNTx and on every s_ack_i.
  - It increments each GNTx cycle with s_stb_o=1 and s_ack_i=0.
  - When the counter equals TIMEOUT_CYCLES-1 with no ack, the next edge enters ABORT.
  - ABORT: s_cyc_o = s_stb_o = 0; mx_err_o = 1 for exactly one cycle (the first ABORT cycle). ABORT then holds until mx_cyc_i = 0, then goes to IDLE.
  - s_ack_i in ABORT is ignored.
- Without the macro: no counter, no ABORT state; m0_err_o and m1_err_o are tied to 0.

Test Plan:
- Reset with rst_ni=0, then release → all s_* = 0, both ack/err = 0, state IDLE.
- m0 only, word write adr=0x80000010, dat=0xDEADBEEF, sel=0xF; slave acks after 3 cycles → s_cyc_o high one cycle after the request. s_adr_o=0x80000010, s_dat_o=0xDEADBEEF. m0_ack_o pulses once; m1_ack_o stays 0.
- Round-robin (ARB_MODE=0), both request continuously, each cycle acked once → grants alternate m0, m1, m0, m1 with a 1-cycle IDLE gap between them.
- Fixed priority (ARB_MODE=1), both requesting continuously → m0 is granted every time; m1 is granted only after m0 holds cyc low through an IDLE edge.
- m1 read of 0x00001000; slave returns 0x12345678 with ack in the same cycle m1_cyc_i drops → m1_ack_o=1 and m1_dat_o=0x12345678. A pending m0 request is then granted one edge after IDLE.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks m0 → s_cyc_o falls after 4 grant cycles. m0_err_o is high for one cycle; the arbiter stays in ABORT until m0_cyc_i=0, then returns to IDLE.
